// File: rtl/fifo_pkg.sv
// Shared helpers for the packing/unpacking FIFOs.
// Width functions: clog2, lane-select width, count width.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Lane-count exponent for the legal lane counts.
  function automatic int sfbit(input int n);
    int r;
    case (n)
      1:       r = 0;
      2:       r = 1;
      4:       r = 2;
      8:       r = 3;
      16:      r = 4;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Width able to hold 0..depth.
  function automatic int cwidth(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lane_packer.sv
// Collects narrow words into lanes (first word -> MS lane).
// Ports: wacc_i/data_i/last_i write, flush_i partial commit;
// lane_o held lanes, commit_o with word_o/lanes_o/last_o.
module lane_packer
  import fifo_pkg::*;
#(
  parameter int               DSIZE     = 8,
  parameter int               NSIZE     = 4,
  parameter logic [DSIZE-1:0] DEF_VALUE = '0,
  localparam int              LW        = sfbit(NSIZE) + 1,
  localparam int              W         = DSIZE * NSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wacc_i,
  input  logic [DSIZE-1:0] data_i,
  input  logic             last_i,
  input  logic             flush_i,
  output logic [LW-1:0]    lane_o,
  output logic             commit_o,
  output logic [W-1:0]     word_o,
  output logic [LW-1:0]    lanes_o,
  output logic             last_o
);

  logic [LW-1:0]    lane_q, lane_d;
  logic [DSIZE-1:0] dat_q [NSIZE];
  logic [DSIZE-1:0] dat_d [NSIZE];
  logic             top_lane;

  assign lane_o   = lane_q;
  assign top_lane = (lane_q == LW'(NSIZE - 1));

  // Lanes above lane_q are always DEF_VALUE, so the
  // outgoing word needs only the incoming word spliced in.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < NSIZE; i++) begin
      word_o[W-1-i*DSIZE -: DSIZE] = dat_q[i];
      if (wacc_i && lane_q == LW'(i))
        word_o[W-1-i*DSIZE -: DSIZE] = data_i;
    end
  end

  always_comb begin
    commit_o = 1'b0;
    lanes_o  = lane_q;
    last_o   = 1'b1;
    if (wacc_i) begin
      commit_o = top_lane || last_i;
      lanes_o  = lane_q + LW'(1);
      last_o   = last_i;
    end else if (flush_i) begin
      commit_o = (lane_q != '0);
    end
  end

  always_comb begin
    lane_d = lane_q;
    dat_d  = dat_q;
    if (commit_o) begin
      lane_d = '0;
      for (int i = 0; i < NSIZE; i++)
        dat_d[i] = DEF_VALUE;
    end else if (wacc_i) begin
      lane_d = lane_q + LW'(1);
      for (int i = 0; i < NSIZE; i++)
        if (lane_q == LW'(i)) dat_d[i] = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      for (int i = 0; i < NSIZE; i++)
        dat_q[i] <= DEF_VALUE;
    end else begin
      lane_q <= lane_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: rtl/lat_cell.sv
// Fixed-latency delay line: q_o is d_i delayed by LAT clocks.
// Ports: clk, rst_n, d_i[DSIZE], q_o[DSIZE]; resets to zero.
module lat_cell #(
  parameter int LAT   = 1,
  parameter int DSIZE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] d_i,
  output logic [DSIZE-1:0] q_o
);

  logic [DSIZE-1:0] pipe_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[LAT-1];

endmodule

// File: rtl/fifo_1ton.sv
// Narrow-to-wide packing FIFO, single clock, 1-cycle read.
// Write: wr_en/wr_data/wr_last/wr_flush; read: rd_en -> rd_*.
module fifo_1ton
  import fifo_pkg::*;
#(
  parameter int               DSIZE     = 8,
  parameter int               NSIZE     = 4,
  parameter int               DEPTH     = 4,
  parameter int               ALMOST    = 1,
  parameter logic [DSIZE-1:0] DEF_VALUE = '0,
  localparam int              SFBIT     = sfbit(NSIZE),
  localparam int              CSIZE     = cwidth(DEPTH),
  localparam int              W         = DSIZE * NSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_last,
  input  logic             wr_flush,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic [SFBIT:0]   wr_lane,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [SFBIT:0]   rd_lanes,
  output logic             rd_last,
  output logic             rd_vld,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic [CSIZE-1:0] count
);

  localparam int PSIZE = clog2(DEPTH);

  logic [W-1:0]     mem_q   [DEPTH];
  logic [SFBIT:0]   mlanes_q[DEPTH];
  logic             mlast_q [DEPTH];
  logic [PSIZE-1:0] wptr_q, rptr_q;
  logic [CSIZE-1:0] count_q, count_d;
  logic [W-1:0]     rd_data_q;
  logic [SFBIT:0]   rd_lanes_q;
  logic             rd_last_q;

  logic             wacc, racc, flush_only;
  logic             commit, p_last;
  logic [W-1:0]     p_word;
  logic [SFBIT:0]   p_lanes;

  function automatic logic [PSIZE-1:0] nxt(
    input logic [PSIZE-1:0] p
  );
    return (p == PSIZE'(DEPTH - 1)) ? '0 : p + PSIZE'(1);
  endfunction

  assign wr_full         = (count_q == CSIZE'(DEPTH));
  assign wr_almost_full  = (count_q >= CSIZE'(DEPTH - ALMOST));
  assign rd_empty        = (count_q == '0);
  assign rd_almost_empty = (count_q <= CSIZE'(ALMOST));
  assign count           = count_q;

  assign wacc       = wr_en && !wr_full;
  assign racc       = rd_en && !rd_empty;
  assign flush_only = wr_flush && !wr_en && !wr_full;

  lane_packer #(
    .DSIZE     (DSIZE),
    .NSIZE     (NSIZE),
    .DEF_VALUE (DEF_VALUE)
  ) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .wacc_i   (wacc),
    .data_i   (wr_data),
    .last_i   (wr_last || wr_flush),
    .flush_i  (flush_only),
    .lane_o   (wr_lane),
    .commit_o (commit),
    .word_o   (p_word),
    .lanes_o  (p_lanes),
    .last_o   (p_last)
  );

  lat_cell #(
    .LAT   (1),
    .DSIZE (1)
  ) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (racc),
    .q_o   (rd_vld)
  );

  always_comb begin
    count_d = count_q;
    unique case ({commit, racc})
      2'b10:   count_d = count_q + CSIZE'(1);
      2'b01:   count_d = count_q - CSIZE'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]    <= {NSIZE{DEF_VALUE}};
        mlanes_q[i] <= '0;
        mlast_q[i]  <= 1'b0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (commit) begin
        mem_q[wptr_q]    <= p_word;
        mlanes_q[wptr_q] <= p_lanes;
        mlast_q[wptr_q]  <= p_last;
        wptr_q           <= nxt(wptr_q);
      end
      if (racc)
        rptr_q <= nxt(rptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= {NSIZE{DEF_VALUE}};
      rd_lanes_q <= '0;
      rd_last_q  <= 1'b0;
    end else if (racc) begin
      rd_data_q  <= mem_q[rptr_q];
      rd_lanes_q <= mlanes_q[rptr_q];
      rd_last_q  <= mlast_q[rptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_lanes = rd_lanes_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_fifo_1ton.sv
// Directed bench for fifo_1ton (8-bit x 4 lanes, depth 4).
// Checks flow through chk(); a small model scores the stress run.
module tb_fifo_1ton;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_last = 1'b0;
  logic        wr_flush = 1'b0;
  logic        wr_full, wr_almost_full;
  logic [2:0]  wr_lane;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic [2:0]  rd_lanes;
  logic        rd_last, rd_vld, rd_empty, rd_almost_empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  int          mcount = 0;
  int          mlane = 0;
  logic [31:0] mword = '0;
  bit          last_wacc;

  fifo_1ton #(
    .DSIZE     (8),
    .NSIZE     (4),
    .DEPTH     (4),
    .ALMOST    (1),
    .DEF_VALUE (8'h00)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_last         (wr_last),
    .wr_flush        (wr_flush),
    .wr_full         (wr_full),
    .wr_almost_full  (wr_almost_full),
    .wr_lane         (wr_lane),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_lanes        (rd_lanes),
    .rd_last         (rd_last),
    .rd_vld          (rd_vld),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .count           (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit last = 1'b0);
    wr_en = 1'b1;
    wr_data = d;
    wr_last = last;
    tick();
    wr_en = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic rd;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic step(input bit we, input logic [7:0] d, input bit re);
    bit          racc_m;
    logic [31:0] want;
    want = '0;
    last_wacc = we && (mcount < 4);
    racc_m = re && (mcount > 0);
    if (racc_m) want = sb.pop_front();
    wr_en = we;
    wr_data = d;
    rd_en = re;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (last_wacc) begin
      mword[31-8*mlane -: 8] = d;
      if (mlane == 3) begin
        sb.push_back(mword);
        mword = '0;
        mlane = 0;
        mcount++;
      end else begin
        mlane++;
      end
    end
    if (racc_m) mcount--;
    chk("sb_vld", rd_vld, racc_m);
    if (racc_m) chk("sb_data", rd_data, want);
    chk("sb_cnt", count, mcount);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"}, count, 0);
    chk({tag, "_full"}, wr_full, 0);
    chk({tag, "_afull"}, wr_almost_full, 0);
    chk({tag, "_lane"}, wr_lane, 0);
    chk({tag, "_empty"}, rd_empty, 1);
    chk({tag, "_aempty"}, rd_almost_empty, 1);
    chk({tag, "_vld"}, rd_vld, 0);
    chk({tag, "_last"}, rd_last, 0);
    chk({tag, "_lanes"}, rd_lanes, 0);
    chk({tag, "_data"}, rd_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc;
    logic [7:0] words [32];

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state, read on empty, flush with empty packer
    chk_reset("rst");
    rd();
    chk("empty_rd_vld", rd_vld, 0);
    chk("empty_rd_data", rd_data, 32'h0);
    chk("empty_rd_cnt", count, 0);
    wr_flush = 1'b1;
    tick();
    wr_flush = 1'b0;
    chk("flush0_cnt", count, 0);
    chk("flush0_lane", wr_lane, 0);

    // full word
    wr(8'h11); wr(8'h22); wr(8'h33);
    chk("t1_lane3", wr_lane, 3);
    wr(8'h44);
    chk("t1_cnt1", count, 1);
    chk("t1_lane0", wr_lane, 0);
    chk("t1_nempty", rd_empty, 0);
    chk("t1_aempty", rd_almost_empty, 1);
    rd();
    chk("t1_vld", rd_vld, 1);
    chk("t1_data", rd_data, 32'h11223344);
    chk("t1_lanes", rd_lanes, 4);
    chk("t1_last", rd_last, 0);
    chk("t1_cnt0", count, 0);
    chk("t1_empty", rd_empty, 1);
    tick();
    chk("t1_vld_drop", rd_vld, 0);

    // partial words: wr_last and wr_flush
    wr(8'hAA); wr(8'hBB, 1'b1);
    chk("t2_cnt", count, 1);
    rd();
    chk("t2_data", rd_data, 32'hAABB0000);
    chk("t2_lanes", rd_lanes, 2);
    chk("t2_last", rd_last, 1);
    wr(8'hCC);
    chk("t2_lane1", wr_lane, 1);
    wr_flush = 1'b1;
    tick();
    wr_flush = 1'b0;
    chk("t2_fl_cnt", count, 1);
    chk("t2_fl_lane", wr_lane, 0);
    rd();
    chk("t2f_data", rd_data, 32'hCC000000);
    chk("t2f_lanes", rd_lanes, 1);
    chk("t2f_last", rd_last, 1);

    // overfill
    for (int i = 0; i < 20; i++) begin
      wr(8'(i));
      if (i == 14) begin
        chk("t3_cnt3", count, 3);
        chk("t3_nfull", wr_full, 0);
        chk("t3_afull", wr_almost_full, 1);
      end
      if (i == 15) begin
        chk("t3_full", wr_full, 1);
        chk("t3_cnt4", count, 4);
      end
    end
    chk("t3_lane_drop", wr_lane, 0);
    chk("t3_cnt_drop", count, 4);
    for (int j = 0; j < 4; j++) begin
      rd();
      chk("t3_data", rd_data, 32'h00010203 + 32'h04040404 * j);
      chk("t3_lanes", rd_lanes, 4);
    end
    chk("t3_empty", rd_empty, 1);
    chk("t3_aempty", rd_almost_empty, 1);

    // full-boundary stress with scoreboard
    for (int i = 0; i < 16; i++)
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    chk("t4_full", wr_full, 1);
    for (int i = 0; i < 32; i++)
      words[i] = 8'($urandom_range(0, 255));
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 200) begin
      step(1'b1, words[k], mcount == 4);
      if (cyc == 0) chk("t4_rej", last_wacc, 0);
      if (cyc == 1) chk("t4_acc", last_wacc, 1);
      chk("t4_rng", (count >= 3 && count <= 4), 1);
      if (last_wacc) k++;
      cyc++;
    end
    chk("t4_done", k, 32);
    cyc = 0;
    while (mcount > 0 && cyc < 20) begin
      step(1'b0, 8'h00, 1'b1);
      cyc++;
    end
    chk("t4_empty", rd_empty, 1);

    // async reset mid-operation
    for (int i = 0; i < 11; i++)
      wr(8'h50 + 8'(i));
    chk("t6_cnt2", count, 2);
    chk("t6_lane3", wr_lane, 3);
    rd();
    chk("t6_vld", rd_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    chk("t6_cnt", count, 1);
    rd();
    chk("t6_data", rd_data, 32'hA0A1A2A3);
    chk("t6_lanes", rd_lanes, 4);
    chk("t6_last", rd_last, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
